// File: rtl/xgmac_tx_pkt_fifo.sv
// rtl/xgmac_tx_pkt_fifo.sv - store-and-forward AXI-Stream frame buffer feeding the xgmac tx_axis port
module xgmac_tx_pkt_fifo #(
    parameter int ADDR_W = 9,
    parameter int CNT_W  = 16
) (
    input  logic             clk156,
    input  logic             reset,
    input  logic [63:0]      s_axis_tdata,
    input  logic [7:0]       s_axis_tkeep,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tlast,
    input  logic             s_axis_tuser,
    output logic             s_axis_tready,
    output logic [63:0]      m_axis_tdata,
    output logic [7:0]       m_axis_tkeep,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    output logic             m_axis_tuser,
    input  logic             m_axis_tready,
    output logic             drop_pulse,
    output logic [CNT_W-1:0] drop_count
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_XFER = 1'b1;

    logic [72:0]       mem      [0:DEPTH-1];
    logic              last_mem [0:DEPTH-1];

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] wr_commit;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] frames_avail;
    logic [ADDR_W-1:0] wr_ptr_inc;
    logic              dropping;

    logic              wr_beat;
    logic              ram_full;
    logic              drop_beat;
    logic              wr_en;
    logic              commit;
    logic              discard;

    logic              state;
    logic              state_next;
    logic              fetch;
    logic              fetch_last;
    logic              room;
    logic [1:0]        occ_next;
    logic              pop;
    logic [ADDR_W-1:0] avail_next;

    logic [72:0]       rd_data;
    logic              rd_valid;
    logic [72:0]       sk_data;
    logic              sk_valid;

    // ---------------- write side ----------------
    assign wr_ptr_inc = wr_ptr + 1'b1;
    assign wr_beat    = s_axis_tvalid & s_axis_tready;
    assign ram_full   = (wr_ptr_inc == rd_ptr);
    assign drop_beat  = dropping | ram_full;
    assign wr_en      = wr_beat & ~drop_beat;
    assign commit     = wr_beat & s_axis_tlast & ~drop_beat & ~s_axis_tuser;
    assign discard    = wr_beat & s_axis_tlast & (drop_beat | s_axis_tuser);

    always_ff @(posedge clk156) begin
        if (reset) begin
            s_axis_tready <= 1'b0;
            wr_ptr        <= '0;
            wr_commit     <= '0;
            dropping      <= 1'b0;
            drop_pulse    <= 1'b0;
            drop_count    <= '0;
        end else begin
            s_axis_tready <= 1'b1;
            drop_pulse    <= discard;
            if (discard) begin
                // Rewind over whatever part of the frame made it into RAM.
                wr_ptr   <= wr_commit;
                dropping <= 1'b0;
                if (drop_count != {CNT_W{1'b1}})
                    drop_count <= drop_count + 1'b1;
            end else begin
                if (wr_en)
                    wr_ptr <= wr_ptr_inc;
                if (wr_beat && ram_full)
                    dropping <= 1'b1;
            end
            if (commit)
                wr_commit <= wr_ptr_inc;
        end
    end

    // RAM data has no reset; the tlast shadow gives the fetcher frame boundaries without waiting on read latency.
    always_ff @(posedge clk156) begin
        if (wr_en) begin
            mem[wr_ptr]      <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
            last_mem[wr_ptr] <= s_axis_tlast;
        end
        if (fetch)
            rd_data <= mem[rd_ptr];
    end

    // ---------------- read side ----------------
    assign pop        = m_axis_tvalid & m_axis_tready;
    assign occ_next   = {1'b0, m_axis_tvalid} + {1'b0, sk_valid} + {1'b0, rd_valid} - {1'b0, pop};
    assign room       = (occ_next < 2'd2);
    assign fetch_last = last_mem[rd_ptr];

    always_comb begin
        fetch      = 1'b0;
        state_next = state;
        case (state)
            ST_IDLE: fetch = room && (frames_avail != '0);
            ST_XFER: fetch = room;
            default: fetch = 1'b0;
        endcase
        if (fetch)
            state_next = (fetch_last && avail_next == '0) ? ST_IDLE : ST_XFER;
    end

    always_comb begin
        avail_next = frames_avail;
        case ({commit, fetch & fetch_last})
            2'b10:   avail_next = frames_avail + 1'b1;
            2'b01:   avail_next = frames_avail - 1'b1;
            default: avail_next = frames_avail;
        endcase
    end

    always_ff @(posedge clk156) begin
        if (reset) begin
            state        <= ST_IDLE;
            rd_ptr       <= '0;
            frames_avail <= '0;
            rd_valid     <= 1'b0;
        end else begin
            state        <= state_next;
            frames_avail <= avail_next;
            rd_valid     <= fetch;
            if (fetch)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // ---------------- output skid buffer ----------------
    // Head register drives m_axis_*; sk_* absorbs the RAM word already in flight when the head stalls.
    always_ff @(posedge clk156) begin
        if (reset) begin
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
            sk_data       <= '0;
            sk_valid      <= 1'b0;
        end else if (!m_axis_tvalid || pop) begin
            if (sk_valid) begin
                {m_axis_tlast, m_axis_tkeep, m_axis_tdata} <= sk_data;
                m_axis_tvalid <= 1'b1;
                if (rd_valid)
                    sk_data <= rd_data;
                else
                    sk_valid <= 1'b0;
            end else if (rd_valid) begin
                {m_axis_tlast, m_axis_tkeep, m_axis_tdata} <= rd_data;
                m_axis_tvalid <= 1'b1;
            end else begin
                m_axis_tvalid <= 1'b0;
            end
        end else if (rd_valid) begin
            sk_data  <= rd_data;
            sk_valid <= 1'b1;
        end
    end

    assign m_axis_tuser = 1'b0;

endmodule

// File: tb/tb_xgmac_tx_pkt_fifo.sv
// tb/tb_xgmac_tx_pkt_fifo.sv - scoreboard bench for xgmac_tx_pkt_fifo
module tb_xgmac_tx_pkt_fifo;

    logic        clk156 = 1'b0;
    logic        reset;
    logic [63:0] s_axis_tdata;
    logic [7:0]  s_axis_tkeep;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tuser;
    logic        s_axis_tready;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        m_axis_tready;
    logic        drop_pulse;
    logic [15:0] drop_count;

    xgmac_tx_pkt_fifo dut (
        .clk156        (clk156),
        .reset         (reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tready (m_axis_tready),
        .drop_pulse    (drop_pulse),
        .drop_count    (drop_count)
    );

    always #5 clk156 = ~clk156;

    int unsigned cyc = 0;
    always @(posedge clk156) cyc <= cyc + 1;

    int          checks = 0;
    int          passes = 0;
    logic [72:0] exp_q[$];
    int          model_drops = 0;
    int          pulse_cnt = 0;
    int          out_beats = 0;
    int unsigned first_out_cyc = 0;
    int unsigned last_out_cyc = 0;
    int unsigned last_cyc = 0;
    int          rdy_mode = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(posedge clk156) begin
        #1;
        case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = 1'($urandom_range(0, 1));
            default: m_axis_tready = 1'b0;
        endcase
    end

    bit          in_frame = 0;
    bit          hold_v = 0;
    logic [73:0] hold;
    logic [72:0] e;
    always @(negedge clk156) begin
        if (reset) begin
            in_frame = 0;
            hold_v   = 0;
        end else begin
            if (drop_pulse) pulse_cnt++;
            if (hold_v)
                check("stable", {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid}, hold);
            if (in_frame && m_axis_tready)
                check("tvalid_gap", m_axis_tvalid, 1);
            hold_v = m_axis_tvalid && !m_axis_tready;
            hold   = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid};
            if (m_axis_tvalid && m_axis_tready) begin
                check("tuser", m_axis_tuser, 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_beat: got %0h expected none", {m_axis_tlast, m_axis_tkeep, m_axis_tdata});
                end else begin
                    e = exp_q.pop_front();
                    check("beat", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, e);
                end
                in_frame = !m_axis_tlast;
                if (out_beats == 0) first_out_cyc = cyc;
                last_out_cyc = cyc;
                out_beats++;
            end
        end
    end

    // Frames longer than the 511 usable slots or flagged bad never reach the output.
    task automatic send_frame(input int len, input bit bad, input logic [7:0] lkeep,
                              input bit gaps, input bit record);
        logic [63:0] d;
        logic [7:0]  k;
        bit          good;
        bit          last;
        good = !bad && (len <= 511);
        for (int i = 0; i < len; i++) begin
            if (gaps)
                while ($urandom_range(0, 3) == 0) begin
                    s_axis_tvalid = 1'b0;
                    @(posedge clk156); #1;
                end
            d    = {$urandom, $urandom};
            last = (i == len - 1);
            k    = last ? lkeep : 8'hFF;
            s_axis_tdata  = d;
            s_axis_tkeep  = k;
            s_axis_tlast  = last;
            s_axis_tuser  = last & bad;
            s_axis_tvalid = 1'b1;
            if (last) last_cyc = cyc;
            if (good && record) exp_q.push_back({last, k, d});
            @(posedge clk156); #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        if (!good) model_drops++;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20000 && exp_q.size() > 0; i++) @(posedge clk156);
        repeat (8) @(posedge clk156);
        #1;
        check("drain", exp_q.size(), 0);
    endtask

    function automatic logic [7:0] rand_keep();
        logic [7:0] ones = 8'hFF;
        return ones >> $urandom_range(0, 7);
    endfunction

    initial begin
        #900000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int len;
        reset = 1'b1;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0;
        s_axis_tlast = 1'b0; s_axis_tuser = 1'b0; m_axis_tready = 1'b1;
        repeat (3) @(posedge clk156);
        @(negedge clk156);
        check("rst_s_tready", s_axis_tready, 0);
        check("rst_m_tvalid", m_axis_tvalid, 0);
        check("rst_m_tdata", m_axis_tdata, 0);
        check("rst_m_tkeep", m_axis_tkeep, 0);
        check("rst_m_tlast", m_axis_tlast, 0);
        check("rst_m_tuser", m_axis_tuser, 0);
        check("rst_drop_pulse", drop_pulse, 0);
        check("rst_drop_count", drop_count, 0);
        @(posedge clk156); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk156); #1;
        check("s_tready_up", s_axis_tready, 1);

        // 1: single 8-beat frame, latency and contiguity
        out_beats = 0;
        send_frame(8, 0, 8'h0F, 0, 1);
        wait_drain();
        check("t1_beats", out_beats, 8);
        check("t1_latency", first_out_cyc - last_cyc, 3);
        check("t1_span", last_out_cyc - first_out_cyc, 7);

        // 2: tuser-flagged frame dropped, next frame intact
        out_beats = 0;
        send_frame(5, 1, 8'hFF, 0, 1);
        send_frame(6, 0, 8'h03, 0, 1);
        wait_drain();
        check("t2_beats", out_beats, 6);
        check("t2_pulses", pulse_cnt, model_drops);
        check("t2_count", drop_count, model_drops);

        // 3: oversize frame dropped, following frame unaffected
        out_beats = 0;
        send_frame(600, 0, 8'hFF, 0, 1);
        send_frame(64, 0, 8'h7F, 0, 1);
        wait_drain();
        check("t3_beats", out_beats, 64);
        check("t3_pulses", pulse_cnt, model_drops);
        check("t3_count", drop_count, model_drops);

        // 4: 100 back-to-back single-beat frames at full rate
        out_beats = 0;
        for (int i = 0; i < 100; i++) send_frame(1, 0, rand_keep(), 0, 1);
        wait_drain();
        check("t4_beats", out_beats, 100);
        check("t4_rate", last_out_cyc - first_out_cyc, 99);

        // 5: random lengths, gaps, bad frames and back-pressure
        rdy_mode = 1;
        for (int f = 0; f < 20; f++) begin
            len = $urandom_range(1, 200);
            for (int w = 0; w < 5000 && exp_q.size() + len > 500; w++) @(posedge clk156);
            #1;
            check("t5_room_wait", (exp_q.size() + len) <= 500, 1);
            send_frame(len, $urandom_range(0, 4) == 0, rand_keep(), 1, 1);
        end
        wait_drain();
        rdy_mode = 0;
        repeat (4) @(posedge clk156); #1;
        check("t5_pulses", pulse_cnt, model_drops);
        check("t5_count", drop_count, model_drops);

        // 6: reset with stored frames and one frame in progress
        rdy_mode = 2;
        repeat (2) @(posedge clk156); #1;
        for (int f = 0; f < 3; f++) send_frame(4, 0, 8'hFF, 0, 0);
        for (int i = 0; i < 3; i++) begin
            s_axis_tdata = {$urandom, $urandom}; s_axis_tkeep = 8'hFF;
            s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
            @(posedge clk156); #1;
        end
        s_axis_tvalid = 1'b0;
        reset = 1'b1;
        @(posedge clk156); #1;
        reset = 1'b0;
        exp_q.delete();
        model_drops = 0;
        pulse_cnt = 0;
        @(negedge clk156);
        check("t6_tvalid", m_axis_tvalid, 0);
        check("t6_count", drop_count, 0);
        rdy_mode = 0;
        out_beats = 0;
        @(posedge clk156); #1;
        @(posedge clk156); #1;
        send_frame(10, 0, 8'h1F, 0, 1);
        wait_drain();
        check("t6_beats", out_beats, 10);
        check("t6_pulses", pulse_cnt, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
